noc_vc_input_port: RTL and testbench

//  Parametrised router input port for the mesh/torus NoC: NUM_VC virtual-channel FIFOs of DEPTH flits,
//  per-VC full back-pressure, round-robin VC arbitration and XY (mesh) or shortest-path (torus) route

---
 rtl/noc_vc_input_port.sv | 199 +++++++++++++++++++
 tb/tb_noc_vc_input_port.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_input_port.sv
`default_nettype none
// ============================================================================
// Module      : noc_vc_input_port
// Description : NoC router input port. It holds NUM_VC virtual-channel FIFOs
//               of DEPTH flits each and signals per-VC full back-pressure
//               upstream. Head flits are chosen by round-robin arbitration,
//               and each flit is routed XY (mesh) or shortest-path (torus).
// Revision    : 1.0 - initial release
// ============================================================================
module noc_vc_input_port #(
  parameter int W      = 32,
  parameter int NUM_VC = 4,
  parameter int DEPTH  = 4,
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int T      = 0,
  localparam int VCB   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        current_address,
  input  logic              in_valid,
  input  logic [W-1:0]      in_flit,
  output logic [NUM_VC-1:0] full_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_flit,
  output logic [VCB-1:0]    out_vc,
  output logic [2:0]        out_port,
  output logic              overflow_err,
  output logic              route_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [VCB:0]    C_NUM_VC = (VCB + 1)'(NUM_VC);
  localparam logic [CW-1:0]   C_DEPTH  = CW'(DEPTH);
  localparam logic [PW-1:0]   C_LAST   = PW'(DEPTH - 1);
  localparam logic [VCB-1:0]  C_LASTVC = VCB'(NUM_VC - 1);

  // Per-VC storage and bookkeeping
  logic [W-1:0]  mem_q    [NUM_VC][DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_VC];
  logic [PW-1:0] rd_ptr_q [NUM_VC];
  logic [CW-1:0] cnt_q    [NUM_VC];
  logic [VCB-1:0] rr_q;

  // Output register
  logic           out_valid_q;
  logic [W-1:0]   out_flit_q;
  logic [VCB-1:0] out_vc_q;
  logic [2:0]     out_port_q;
  logic           overflow_err_q;
  logic           route_err_q;

  // Combinational control
  logic [VCB-1:0]    in_vc_d;
  logic [NUM_VC-1:0] push_d;
  logic [NUM_VC-1:0] pop_d;
  logic              ovf_d;
  logic              ld_d;
  logic              found_d;
  logic [VCB-1:0]    grant_d;
  logic [W-1:0]      head_d;
  logic              bad_d;
  logic [2:0]        port_d;
  logic [VCB-1:0]    rr_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_LAST) ? '0 : p + PW'(1);
  endfunction

  // Mesh: plain XY. Torus: wrap-aware distance, ties go in the + direction.
  function automatic logic [2:0] route_f(input logic [3:0] cr, input logic [3:0] cc,
                                         input logic [3:0] dr, input logic [3:0] dc);
    int dx;
    int dy;
    logic [2:0] p;
    dx = 0;
    dy = 0;
    p  = 3'd0;
    if (T == 0) begin
      if (dc > cc)      p = 3'd3;
      else if (dc < cc) p = 3'd4;
      else if (dr > cr) p = 3'd1;
      else if (dr < cr) p = 3'd2;
      else              p = 3'd0;
    end else begin
      dx = ((int'(dc) - int'(cc)) % N + N) % N;
      dy = ((int'(dr) - int'(cr)) % M + M) % M;
      if (dx != 0)      p = (dx <= N / 2) ? 3'd3 : 3'd4;
      else if (dy != 0) p = (dy <= M / 2) ? 3'd1 : 3'd2;
      else              p = 3'd0;
    end
    return p;
  endfunction

  // Write decode: a flit to a full or non-existent VC is dropped and flagged
  always_comb begin
    in_vc_d = in_flit[W-1 -: VCB];
    push_d  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_d[v] = in_valid && ({1'b0, in_vc_d} < C_NUM_VC) &&
                  (in_vc_d == VCB'(v)) && (cnt_q[v] != C_DEPTH);
    end
    ovf_d = in_valid && (push_d == '0);
  end

  // Round-robin search from the pointer, then route the granted head flit
  always_comb begin
    int idx;
    idx     = 0;
    found_d = 1'b0;
    grant_d = '0;
    ld_d    = !out_valid_q || out_ready;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (int'(rr_q) + i) % NUM_VC;
      if (!found_d && (cnt_q[idx] != '0)) begin
        found_d = 1'b1;
        grant_d = VCB'(idx);
      end
    end
    head_d = mem_q[grant_d][rd_ptr_q[grant_d]];
    bad_d  = (32'(head_d[7:4]) >= M) || (32'(head_d[3:0]) >= N);
    port_d = route_f(current_address[7:4], current_address[3:0], head_d[7:4], head_d[3:0]);
    pop_d  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      pop_d[v] = ld_d && found_d && (grant_d == VCB'(v));
    end
    rr_d = (grant_d == C_LASTVC) ? '0 : grant_d + VCB'(1);
  end

  // Flit storage, written at the VC's tail pointer
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_d[v]) mem_q[v][wr_ptr_q[v]] <= in_flit;
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (clr) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end else begin
        if (push_d[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
        if (pop_d[v])  rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
        case ({push_d[v], pop_d[v]})
          2'b10:   cnt_q[v] <= cnt_q[v] + CW'(1);
          2'b01:   cnt_q[v] <= cnt_q[v] - CW'(1);
          default: cnt_q[v] <= cnt_q[v];
        endcase
      end
    end
  end

  // Output register, arbitration pointer and sticky error flags
  always_ff @(posedge clk) begin
    if (clr) begin
      rr_q           <= '0;
      out_valid_q    <= 1'b0;
      out_flit_q     <= '0;
      out_vc_q       <= '0;
      out_port_q     <= '0;
      overflow_err_q <= 1'b0;
      route_err_q    <= 1'b0;
    end else begin
      if (ovf_d) overflow_err_q <= 1'b1;
      if (ld_d && found_d) begin
        rr_q <= rr_d;
        if (bad_d) route_err_q <= 1'b1;
      end
      if (ld_d) begin
        // A misrouted flit still uses its grant but is never presented
        out_valid_q <= found_d && !bad_d;
        if (found_d && !bad_d) begin
          out_flit_q <= head_d;
          out_vc_q   <= grant_d;
          out_port_q <= port_d;
        end
      end
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_full
    assign full_out[v] = (cnt_q[v] == C_DEPTH);
  end

  assign out_valid    = out_valid_q;
  assign out_flit     = out_flit_q;
  assign out_vc       = out_vc_q;
  assign out_port     = out_port_q;
  assign overflow_err = overflow_err_q;
  assign route_err    = route_err_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_vc_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_vc_input_port
// Description : Directed scoreboard bench. A 4x4 mesh port and a 4x4 torus
//               port are driven independently; each flit's expected port
//               and VC are queued when driven and compared on handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_vc_input_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;

  logic [7:0]  m_addr;
  logic        m_valid;
  logic [31:0] m_flit;
  logic [3:0]  m_full;
  logic        m_ovalid;
  logic        m_ready;
  logic [31:0] m_oflit;
  logic [1:0]  m_ovc;
  logic [2:0]  m_oport;
  logic        m_ovf;
  logic        m_rerr;

  logic [7:0]  t_addr;
  logic        t_valid;
  logic [31:0] t_flit;
  logic [3:0]  t_full;
  logic        t_ovalid;
  logic        t_ready;
  logic [31:0] t_oflit;
  logic [1:0]  t_ovc;
  logic [2:0]  t_oport;
  logic        t_ovf;
  logic        t_rerr;

  noc_vc_input_port #(.W(32), .NUM_VC(4), .DEPTH(4), .M(4), .N(4), .T(0)) u_mesh (
    .clk(clk), .clr(clr), .current_address(m_addr), .in_valid(m_valid), .in_flit(m_flit),
    .full_out(m_full), .out_valid(m_ovalid), .out_ready(m_ready), .out_flit(m_oflit),
    .out_vc(m_ovc), .out_port(m_oport), .overflow_err(m_ovf), .route_err(m_rerr));

  noc_vc_input_port #(.W(32), .NUM_VC(4), .DEPTH(4), .M(4), .N(4), .T(1)) u_torus (
    .clk(clk), .clr(clr), .current_address(t_addr), .in_valid(t_valid), .in_flit(t_flit),
    .full_out(t_full), .out_valid(t_ovalid), .out_ready(t_ready), .out_flit(t_oflit),
    .out_vc(t_ovc), .out_port(t_oport), .overflow_err(t_ovf), .route_err(t_rerr));

  typedef struct packed {
    logic [31:0] flit;
    logic [1:0]  vc;
    logic [2:0]  port;
  } exp_t;

  exp_t mq[$];
  exp_t tq[$];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] vc, input logic [7:0] tag, input logic [7:0] dest);
    return {vc, 14'd0, tag, dest};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_m(input logic [1:0] vc, input logic [7:0] tag, input logic [7:0] dest,
                        input logic [2:0] port, input bit expect_out);
    exp_t e;
    m_valid = 1'b1;
    m_flit  = mk(vc, tag, dest);
    e.flit = m_flit;
    e.vc   = vc;
    e.port = port;
    if (expect_out) mq.push_back(e);
    tick();
    m_valid = 1'b0;
  endtask

  task automatic push_t(input logic [7:0] tag, input logic [7:0] dest, input logic [2:0] port);
    exp_t e;
    t_valid = 1'b1;
    t_flit  = mk(2'd0, tag, dest);
    e.flit = t_flit;
    e.vc   = 2'd0;
    e.port = port;
    tq.push_back(e);
    tick();
    t_valid = 1'b0;
  endtask

  task automatic drain_m(input int budget);
    int n;
    n = 0;
    while (mq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("mesh_drain_left", 64'(mq.size()), 64'd0);
  endtask

  task automatic drain_t(input int budget);
    int n;
    n = 0;
    while (tq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("torus_drain_left", 64'(tq.size()), 64'd0);
  endtask

  // Scoreboard pop on every mesh handshake
  always @(negedge clk) begin
    exp_t e;
    if (!clr && m_ovalid && m_ready) begin
      if (mq.size() == 0) check("mesh_unexpected_out", 64'd1, 64'd0);
      else begin
        e = mq.pop_front();
        check("mesh_flit", 64'(m_oflit), 64'(e.flit));
        check("mesh_vc",   64'(m_ovc),   64'(e.vc));
        check("mesh_port", 64'(m_oport), 64'(e.port));
      end
    end
  end

  // Scoreboard pop on every torus handshake
  always @(negedge clk) begin
    exp_t e;
    if (!clr && t_ovalid && t_ready) begin
      if (tq.size() == 0) check("torus_unexpected_out", 64'd1, 64'd0);
      else begin
        e = tq.pop_front();
        check("torus_flit", 64'(t_oflit), 64'(e.flit));
        check("torus_port", 64'(t_oport), 64'(e.port));
      end
    end
  end

  initial begin
    clr     = 1'b1;
    m_addr  = 8'h11;
    m_valid = 1'b0;
    m_flit  = '0;
    m_ready = 1'b0;
    t_addr  = 8'h00;
    t_valid = 1'b0;
    t_flit  = '0;
    t_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", 64'(m_ovalid), 64'd0);
    check("rst_out_flit",  64'(m_oflit),  64'd0);
    check("rst_out_vc",    64'(m_ovc),    64'd0);
    check("rst_out_port",  64'(m_oport),  64'd0);
    check("rst_full_out",  64'(m_full),   64'd0);
    check("rst_overflow",  64'(m_ovf),    64'd0);
    check("rst_route_err", 64'(m_rerr),   64'd0);
    clr = 1'b0;
    tick();

    // Latency: one edge into the FIFO, one more into the output register
    push_m(2'd0, 8'h01, 8'h13, 3'd3, 1'b1);
    check("lat_valid_edge_k", 64'(m_ovalid), 64'd0);
    tick();
    check("lat_valid_edge_k1", 64'(m_ovalid), 64'd1);
    check("lat_port", 64'(m_oport), 64'd3);
    check("lat_vc",   64'(m_ovc),   64'd0);
    m_ready = 1'b1;
    drain_m(10);

    // Mesh XY routes from 0x22, back to back
    m_addr = 8'h22;
    push_m(2'd1, 8'h21, 8'h20, 3'd4, 1'b1);
    push_m(2'd1, 8'h22, 8'h32, 3'd1, 1'b1);
    push_m(2'd1, 8'h23, 8'h02, 3'd2, 1'b1);
    push_m(2'd1, 8'h24, 8'h22, 3'd0, 1'b1);
    drain_m(20);
    check("xy_no_overflow", 64'(m_ovf), 64'd0);

    // Torus routes from 0x00 including wrap and tie cases
    push_t(8'h31, 8'h03, 3'd4);
    push_t(8'h32, 8'h02, 3'd3);
    push_t(8'h33, 8'h30, 3'd2);
    push_t(8'h34, 8'h10, 3'd1);
    push_t(8'h35, 8'h33, 3'd4);
    push_t(8'h36, 8'h00, 3'd0);
    drain_t(20);

    // Back-pressure: fill VC2 while the switch stalls
    m_ready = 1'b0;
    push_m(2'd2, 8'h41, 8'h22, 3'd0, 1'b1);
    push_m(2'd2, 8'h42, 8'h22, 3'd0, 1'b1);
    push_m(2'd2, 8'h43, 8'h22, 3'd0, 1'b1);
    push_m(2'd2, 8'h44, 8'h22, 3'd0, 1'b1);
    check("full_after_4", 64'(m_full), 64'h0);
    push_m(2'd2, 8'h45, 8'h22, 3'd0, 1'b1);
    check("full_after_5", 64'(m_full), 64'h4);
    check("ovf_before_6", 64'(m_ovf), 64'd0);
    push_m(2'd2, 8'h46, 8'h22, 3'd0, 1'b0);
    check("ovf_after_6", 64'(m_ovf), 64'd1);
    check("full_still",  64'(m_full), 64'h4);
    repeat (2) tick();
    check("stall_hold_flit", 64'(m_oflit), 64'(mk(2'd2, 8'h41, 8'h22)));
    check("stall_hold_valid", 64'(m_ovalid), 64'd1);
    m_ready = 1'b1;
    drain_m(20);
    check("full_after_drain", 64'(m_full), 64'h0);

    // Round robin: VC0 loads first, the rest follow from the pointer
    m_ready = 1'b0;
    push_m(2'd0, 8'h50, 8'h22, 3'd0, 1'b1);
    push_m(2'd1, 8'h51, 8'h22, 3'd0, 1'b1);
    push_m(2'd2, 8'h52, 8'h22, 3'd0, 1'b1);
    push_m(2'd3, 8'h53, 8'h22, 3'd0, 1'b1);
    m_ready = 1'b1;
    drain_m(20);

    // Pointer at 1 after the filler: VC1 is served before VC3 despite push order
    m_ready = 1'b0;
    push_m(2'd0, 8'h60, 8'h22, 3'd0, 1'b1);
    push_m(2'd3, 8'h63, 8'h21, 3'd4, 1'b0);
    push_m(2'd1, 8'h61, 8'h23, 3'd3, 1'b0);
    begin
      exp_t e;
      e.flit = mk(2'd1, 8'h61, 8'h23); e.vc = 2'd1; e.port = 3'd3; mq.push_back(e);
      e.flit = mk(2'd3, 8'h63, 8'h21); e.vc = 2'd3; e.port = 3'd4; mq.push_back(e);
    end
    m_ready = 1'b1;
    drain_m(20);

    // Out-of-range destination is consumed and flagged, never presented
    check("rerr_before", 64'(m_rerr), 64'd0);
    push_m(2'd0, 8'h70, 8'h50, 3'd0, 1'b0);
    check("bad_no_valid_k", 64'(m_ovalid), 64'd0);
    tick();
    check("bad_no_valid_k1", 64'(m_ovalid), 64'd0);
    check("rerr_after", 64'(m_rerr), 64'd1);
    push_m(2'd1, 8'h71, 8'h21, 3'd4, 1'b1);
    drain_m(10);

    // Mid-burst clear discards everything
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_m(2'd2, 8'(8'h80 + i), 8'h22, 3'd0, 1'b0);
    check("pre_clr_full", 64'(m_full), 64'h4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_valid", 64'(m_ovalid), 64'd0);
    check("clr_full",  64'(m_full),   64'h0);
    check("clr_ovf",   64'(m_ovf),    64'd0);
    check("clr_rerr",  64'(m_rerr),   64'd0);
    m_ready = 1'b1;
    repeat (3) tick();
    check("post_clr_valid", 64'(m_ovalid), 64'd0);
    check("post_clr_full",  64'(m_full),   64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
